// File: rtl/multiplier.sv
// Sequential WIDTH x WIDTH shift-add multiplier with start/done handshake.
// Produces a 2*WIDTH product on hi/lo after WIDTH+1 edges from an accepted start.
// Optional feature: define MULT_SIGNED_EN to honour is_signed (two's-complement
// product via magnitude conversion and a final negate). Without it every
// product is unsigned and is_signed is ignored.
module multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   a_mag, b_mag;

`ifdef MULT_SIGNED_EN
  logic neg_q, neg_d;
  logic a_neg, b_neg;

  // Magnitude conversion of the operands for a signed request
  always_comb begin
    a_neg = is_signed & dataA[WIDTH-1];
    b_neg = is_signed & dataB[WIDTH-1];
    a_mag = a_neg ? (~dataA + 1'b1) : dataA;
    b_mag = b_neg ? (~dataB + 1'b1) : dataB;
    neg_d = neg_q;
    if (state_q == StIdle && start) begin
      neg_d = a_neg ^ b_neg;
    end
    result = neg_q ? (~p_q + 1'b1) : p_q;
  end

  // Sign flag register
  always_ff @(posedge clk) begin
    if (!rst) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= neg_d;
    end
  end
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;

  // Unsigned only: operands pass straight through
  always_comb begin
    a_mag  = dataA;
    b_mag  = dataB;
    result = p_q;
  end
`endif

  // Next-state logic for the FSM, datapath and registered outputs
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sum     = {1'b0, p_q[2*WIDTH-1:WIDTH]};
    case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d = a_mag;
          p_d     = {{WIDTH{1'b0}}, b_mag};
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // Carry is kept in the extra adder bit and shifted into P
        if (p_q[0]) begin
          sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
        end
        p_d    = {sum, p_q[WIDTH-1:1]};
        cnt_d  = cnt_q + 1'b1;
        busy_d = 1'b1;
        if (cnt_q == LastIter) begin
          state_d = StDone;
        end
      end
      StDone: begin
        p_d     = result;
        hi_d    = result[2*WIDTH-1:WIDTH];
        lo_d    = result[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      p_q     <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier: scoreboard of expected products,
// one task per scenario.
module tb_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic        is_signed;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  multiplier #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dataA     (dataA),
    .dataB     (dataB),
    .is_signed (is_signed),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic s);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = $signed(a);
    sb = $signed(b);
`ifdef MULT_SIGNED_EN
    if (s) return sa * sb;
`endif
    return {32'b0, a} * {32'b0, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one accepted start edge (edge 0); operands are scrambled afterwards
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input bit push);
    dataA     = a;
    dataB     = b;
    is_signed = s;
    start     = 1'b1;
    if (push) sb_q.push_back(model(a, b, s));
    tick();
    start     = 1'b0;
    dataA     = $urandom;
    dataB     = $urandom;
    is_signed = 1'($urandom);
  endtask

  // Advance until done, numbering edges from 'first'; edge_n = 0 on timeout
  task automatic wait_done(input int first, output int edge_n, output int busy_n,
                           output bit overlap);
    edge_n  = 0;
    busy_n  = 0;
    overlap = 1'b0;
    for (int i = first; i <= first + 45; i++) begin
      tick();
      if (busy) busy_n++;
      if (busy && done) overlap = 1'b1;
      if (done) begin
        edge_n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++;
    if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_checks++;
    if (hi !== 32'h0) $display("FAIL reset_hi got %h want 0", hi); else n_pass++;
    n_checks++;
    if (lo !== 32'h0) $display("FAIL reset_lo got %h want 0", lo); else n_pass++;
    rst = 1'b1;
    tick();
  endtask

  // Run one operation from edge 0 and check latency, busy window and product
  task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic s);
    int e, bn;
    bit ov;
    logic [63:0] exp;
    issue(a, b, s, 1'b1);
    wait_done(1, e, bn, ov);
    n_checks++;
    if (e !== 33) $display("FAIL %s_latency got %0d want 33", name, e); else n_pass++;
    n_checks++;
    if (bn !== 32) $display("FAIL %s_busy_cycles got %0d want 32", name, bn); else n_pass++;
    n_checks++;
    if (ov !== 1'b0) $display("FAIL %s_busy_done_overlap got 1 want 0", name); else n_pass++;
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    n_checks++;
    if ({hi, lo} !== exp) $display("FAIL %s_product got %h want %h", name, {hi, lo}, exp);
    else n_pass++;
  endtask

  task automatic test_basic();
    run_one("basic_3x5", 32'd3, 32'd5, 1'b0);
    tick();
    n_checks++;
    if (done !== 1'b0) $display("FAIL basic_done_pulse got %b want 0", done); else n_pass++;
    n_checks++;
    if (lo !== 32'd15) $display("FAIL basic_lo_hold got %h want f", lo); else n_pass++;
  endtask

  task automatic test_max_carry();
    run_one("max_unsigned", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    n_checks++;
    if (hi !== 32'hFFFF_FFFE) $display("FAIL max_hi got %h want fffffffe", hi); else n_pass++;
  endtask

  task automatic test_signed();
    run_one("signed_m1x2", 32'hFFFF_FFFF, 32'd2, 1'b1);
`ifdef MULT_SIGNED_EN
    n_checks++;
    if (hi !== 32'hFFFF_FFFF) $display("FAIL signed_hi got %h want ffffffff", hi); else n_pass++;
`else
    n_checks++;
    if (hi !== 32'h0000_0001) $display("FAIL signed_hi got %h want 00000001", hi); else n_pass++;
`endif
    run_one("signed_m3xm5", 32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b1);
    run_one("signed_min", 32'h8000_0000, 32'h8000_0000, 1'b1);
    run_one("signed_off", 32'hFFFF_FFFF, 32'd2, 1'b0);
  endtask

  task automatic test_ignore_start();
    int e, bn, dn;
    bit ov;
    logic [63:0] exp;
    issue(32'd7, 32'd9, 1'b0, 1'b1);
    for (int i = 1; i <= 9; i++) tick();
    dataA = 32'd1;
    dataB = 32'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(11, e, bn, ov);
    n_checks++;
    if (e !== 33) $display("FAIL ignore_latency got %0d want 33", e); else n_pass++;
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    n_checks++;
    if ({hi, lo} !== exp) $display("FAIL ignore_product got %h want %h", {hi, lo}, exp);
    else n_pass++;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) dn++;
    end
    n_checks++;
    if (dn !== 0) $display("FAIL ignore_extra_done got %0d want 0", dn); else n_pass++;
    n_checks++;
    if (lo !== 32'd63) $display("FAIL ignore_lo_hold got %h want 3f", lo); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int e, bn;
    bit ov;
    logic [63:0] exp;
    issue(32'd4, 32'd5, 1'b0, 1'b1);
    wait_done(1, e, bn, ov);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    n_checks++;
    if ({hi, lo} !== exp) $display("FAIL b2b_first got %h want %h", {hi, lo}, exp);
    else n_pass++;
    // Still in the done cycle: this start must be accepted
    issue(32'd6, 32'd7, 1'b0, 1'b1);
    wait_done(1, e, bn, ov);
    n_checks++;
    if (e !== 33) $display("FAIL b2b_latency got %0d want 33", e); else n_pass++;
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    n_checks++;
    if ({hi, lo} !== exp) $display("FAIL b2b_second got %h want %h", {hi, lo}, exp);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    int dn;
    issue(32'd10, 32'd10, 1'b0, 1'b0);
    for (int i = 1; i <= 11; i++) tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else n_pass++;
    n_checks++;
    if (hi !== 32'h0) $display("FAIL abort_hi got %h want 0", hi); else n_pass++;
    n_checks++;
    if (lo !== 32'h0) $display("FAIL abort_lo got %h want 0", lo); else n_pass++;
    rst = 1'b1;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) dn++;
    end
    n_checks++;
    if (dn !== 0) $display("FAIL abort_done_pulse got %0d want 0", dn); else n_pass++;
    run_one("after_abort", 32'd2, 32'd4, 1'b0);
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    dataA     = '0;
    dataB     = '0;
    is_signed = 1'b0;
    test_reset();
    test_basic();
    test_max_carry();
    test_signed();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
